// File: rtl/jt7759_romfeed.sv
// jt7759_romfeed -- streams ADPCM phrase bytes from ROM into a 4-entry byte
// FIFO and hands them to the decoder one nibble at a time.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   cen          clock enable for the decoder-side nibble logic
//   cendec       nibble request strobe, qualified by cen
//   start        one-clk pulse that begins (or restarts) a phrase
//   start_addr   first ROM byte address, sampled on start
//   len          phrase length in bytes, sampled on start (0 = empty phrase)
//   rom_cs       ROM read request
//   rom_addr     ROM byte address
//   rom_data     ROM read data
//   rom_ok       rom_data valid for the current rom_addr
//   nib          nibble sent to the decoder (high nibble of each byte first)
//   nib_valid    one-clk pulse: nib was updated
//   busy         a phrase is being fed
//   done         one-clk pulse after the last nibble was delivered
//   underrun     one-clk pulse: a request found the FIFO empty
//   urun_cnt     saturating underrun counter (only with JT7759_UNDERRUN_CNT_EN)
//
// Optional feature: define JT7759_UNDERRUN_CNT_EN to add the urun_cnt port.

module jt7759_romfeed (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        cendec,
  input  logic        start,
  input  logic [16:0] start_addr,
  input  logic [15:0] len,
  output logic        rom_cs,
  output logic [16:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok,
  output logic [3:0]  nib,
  output logic        nib_valid,
  output logic        busy,
  output logic        done,
  output logic        underrun
`ifdef JT7759_UNDERRUN_CNT_EN
  ,
  output logic [7:0]  urun_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;

  state_t      state, state_nx;
  logic [16:0] addr;
  logic [15:0] remaining;
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        half;          // 0: next nibble is [7:4], 1: next is [3:0]
  logic        fifo_empty, fifo_full;
  logic        accept, req, pop;

  assign fifo_empty = (count == 3'd0);
  assign fifo_full  = (count == 3'd4);
  assign rom_addr   = addr;

  // A start in the same clk as rom_ok wins: the byte belongs to the old phrase.
  assign accept = rom_cs && rom_ok && !start;
  // Requests only count while a phrase is active and not being restarted.
  assign req    = cen && cendec && busy && !start;
  // The byte leaves the FIFO together with its low nibble.
  assign pop    = req && !fifo_empty && half;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = (len != 16'd0) ? FETCH : IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        FETCH: begin
          if (accept)                   state_nx = WAIT;
          else if (remaining == 16'd0)  state_nx = DRAIN;
        end
        WAIT:    state_nx = (remaining != 16'd0) ? FETCH : DRAIN;
        DRAIN:   if (fifo_empty) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    rom_cs = 1'b0;
    busy   = 1'b0;
    case (state)
      FETCH: begin
        busy   = 1'b1;
        rom_cs = !fifo_full && (remaining != 16'd0);
      end
      WAIT, DRAIN: busy = 1'b1;
      default: begin
        rom_cs = 1'b0;
        busy   = 1'b0;
      end
    endcase
  end

  // FIFO storage
  // NOTE: the byte array carries no reset; validity is tracked by count and
  // the pointers, which are reset, so stale contents are never read.
  always_ff @(posedge clk) begin
    if (rst_n && accept) fifo_mem[wr_ptr] <= rom_data;
  end

  // Address/length counters, FIFO bookkeeping and decoder-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr      <= 17'd0;
      remaining <= 16'd0;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 3'd0;
      half      <= 1'b0;
      nib       <= 4'd0;
      nib_valid <= 1'b0;
      underrun  <= 1'b0;
      done      <= 1'b0;
    end else begin
      nib_valid <= 1'b0;
      underrun  <= 1'b0;
      done      <= 1'b0;
      if (start) begin
        addr      <= start_addr;
        remaining <= len;
        wr_ptr    <= 2'd0;
        rd_ptr    <= 2'd0;
        count     <= 3'd0;
        half      <= 1'b0;
        done      <= (len == 16'd0);
      end else begin
        if (accept) begin
          wr_ptr    <= wr_ptr + 2'd1;
          addr      <= addr + 17'd1;      // wraps modulo 2^17
          remaining <= remaining - 16'd1;
        end
        if (req) begin
          if (fifo_empty) begin
            underrun <= 1'b1;
          end else begin
            nib_valid <= 1'b1;
            nib       <= half ? fifo_mem[rd_ptr][3:0] : fifo_mem[rd_ptr][7:4];
            half      <= !half;
            if (half) rd_ptr <= rd_ptr + 2'd1;
          end
        end
        // Simultaneous push and pop leave the count unchanged.
        count <= count + {2'b00, accept} - {2'b00, pop};
        // Last low nibble went out on an earlier clk: finish now.
        if (state == DRAIN && fifo_empty) done <= 1'b1;
      end
    end
  end

`ifdef JT7759_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                         urun_cnt <= 8'd0;
    else if (start)                                     urun_cnt <= 8'd0;
    else if (req && fifo_empty && urun_cnt != 8'hFF)    urun_cnt <= urun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_jt7759_romfeed.sv
// Self-checking bench for jt7759_romfeed: directed vector table, hand-written
// corner sequences and randomized traffic, all checked against a
// phrase-level reference model (byte queue + fetch/drain rules).

module tb_jt7759_romfeed;

  logic        clk;
  logic        rst_n, cen, cendec, start;
  logic [16:0] start_addr;
  logic [15:0] len;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic [3:0]  nib;
  logic        nib_valid, busy, done, underrun;
`ifdef JT7759_UNDERRUN_CNT_EN
  logic [7:0]  urun_cnt;
`endif

  jt7759_romfeed dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .cendec     (cendec),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .rom_cs     (rom_cs),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_ok     (rom_ok),
    .nib        (nib),
    .nib_valid  (nib_valid),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
`ifdef JT7759_UNDERRUN_CNT_EN
    ,
    .urun_cnt   (urun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ROM model ----------------
  logic [7:0]  rom_mem [0:131071];
  int          rom_mode;     // 0 normal latency, 1 rom_ok held low, 2 rom_ok forced high
  int          rom_lat;
  int          age;
  logic        cs_prev;
  logic [16:0] prev_addr;

  // ---------------- reference model ----------------
  logic        m_active;
  logic [7:0]  m_fifo[$];
  logic        m_half;
  int          m_fetched, m_len;
  logic [16:0] m_addr;
  logic        m_just_acc;
  logic        m_cs;
  int          m_urun;
  logic [3:0]  e_nib;
  logic        e_nv, e_ur, e_done;

  // observations
  logic [16:0] obs_addrs[$];
  logic [3:0]  obs_nibs[$];
  int          cyc, n_nv, n_ur, n_done, last_nv_cyc, done_cyc;
  logic        busy_at_done;

  task automatic model_edge(input logic r, input logic s, input logic [16:0] sa,
                            input logic [15:0] ln, input logic rq);
    logic [7:0] b;
    logic empty_before, drain_done, acc;
    acc    = m_cs && rom_ok;
    e_nv   = 1'b0;
    e_ur   = 1'b0;
    e_done = 1'b0;
    if (!r) begin
      m_active = 1'b0; m_fifo.delete(); m_half = 1'b0; m_fetched = 0; m_len = 0;
      m_addr = 17'd0; m_just_acc = 1'b0; m_urun = 0; e_nib = 4'd0;
    end else if (s) begin
      m_fifo.delete(); m_half = 1'b0; m_just_acc = 1'b0; m_urun = 0; m_fetched = 0;
      if (ln != 16'd0) begin
        m_active = 1'b1; m_len = int'(ln); m_addr = sa;
      end else begin
        m_active = 1'b0; e_done = 1'b1;
      end
    end else if (m_active) begin
      empty_before = (m_fifo.size() == 0);
      drain_done   = (m_fetched == m_len) && !m_just_acc && empty_before;
      if (rq) begin
        if (empty_before) begin
          e_ur = 1'b1;
          if (m_urun < 255) m_urun++;
        end else begin
          b     = m_fifo[0];
          e_nv  = 1'b1;
          e_nib = m_half ? b[3:0] : b[7:4];
          if (m_half) m_fifo.delete(0);
          m_half = !m_half;
        end
      end
      if (acc) begin
        m_fifo.push_back(rom_mem[m_addr]);
        m_addr = m_addr + 17'd1;
        m_fetched++;
      end
      m_just_acc = acc;
      if (drain_done) m_active = 1'b0;
      e_done = drain_done;
    end
    m_cs = m_active && (m_fetched < m_len) && (m_fifo.size() < 4) && !m_just_acc;
  endtask

  // One clock: ROM response, drive inputs, predict, clock, check, observe.
  task automatic step(input logic r, input logic s, input logic [16:0] sa,
                      input logic [15:0] ln, input logic c, input logic cd);
    if (rom_mode == 1) rom_ok = 1'b0;
    else if (rom_mode == 2) rom_ok = 1'b1;
    else if (rom_cs === 1'b1) begin
      if (cs_prev && rom_addr == prev_addr) age++;
      else age = 1;
      rom_ok = (age >= rom_lat);
    end else begin
      age    = 0;
      rom_ok = 1'b0;
    end
    cs_prev   = (rom_cs === 1'b1);
    prev_addr = rom_addr;
    rom_data  = (rom_cs === 1'b1) ? rom_mem[rom_addr] : 8'h00;

    rst_n = r; start = s; start_addr = sa; len = ln; cen = c; cendec = cd;
    if (r && !s && rom_cs === 1'b1 && rom_ok) obs_addrs.push_back(rom_addr);
    model_edge(r, s, sa, ln, c && cd);

    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("nib_valid", {31'd0, nib_valid}, {31'd0, e_nv});
    check("underrun",  {31'd0, underrun},  {31'd0, e_ur});
    check("done",      {31'd0, done},      {31'd0, e_done});
    check("busy",      {31'd0, busy},      {31'd0, m_active});
    check("nib",       {28'd0, nib},       {28'd0, e_nib});
    check("rom_cs",    {31'd0, rom_cs},    {31'd0, m_cs});
    if (m_cs) check("rom_addr", {15'd0, rom_addr}, {15'd0, m_addr});
`ifdef JT7759_UNDERRUN_CNT_EN
    check("urun_cnt",  {24'd0, urun_cnt},  m_urun);
`endif
    if (nib_valid === 1'b1) begin obs_nibs.push_back(nib); n_nv++; last_nv_cyc = cyc; end
    if (underrun === 1'b1) n_ur++;
    if (done === 1'b1) begin n_done++; done_cyc = cyc; busy_at_done = busy; end
  endtask

  task automatic clear_obs();
    obs_addrs.delete(); obs_nibs.delete();
    n_nv = 0; n_ur = 0; n_done = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [16:0] sa;
    logic [15:0] ln;
    logic [3:0]  lat;
    logic [2:0]  n_addr;
    logic [67:0] addrs;   // first address in the top 17 bits
    logic [3:0]  n_nib;
    logic [31:0] nibs;    // first nibble in the top 4 bits
  } vec_t;

  vec_t vecs [3];

  initial begin
    vec_t        v;
    logic [16:0] ea;
    logic [31:0] got;

    for (int i = 0; i < 131072; i++) rom_mem[i] = 8'((i * 7) + (i >> 5)) ^ 8'h96;
    rom_mem[17'h00100] = 8'hA5; rom_mem[17'h00101] = 8'h3C; rom_mem[17'h00102] = 8'h7E;
    rom_mem[17'h1FFFE] = 8'h12; rom_mem[17'h1FFFF] = 8'h34;
    rom_mem[17'h00000] = 8'h56; rom_mem[17'h00001] = 8'h78;
    rom_mem[17'h00200] = 8'hC3; rom_mem[17'h00201] = 8'h9F;

    vecs[0] = '{17'h00100, 16'd3, 4'd2, 3'd3,
                {17'h00100, 17'h00101, 17'h00102, 17'h00000}, 4'd6, 32'hA53C7E00};
    vecs[1] = '{17'h1FFFE, 16'd4, 4'd1, 3'd4,
                {17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001}, 4'd8, 32'h12345678};
    vecs[2] = '{17'h00200, 16'd2, 4'd3, 3'd2,
                {17'h00200, 17'h00201, 17'h00000, 17'h00000}, 4'd4, 32'hC39F0000};

    rst_n = 1'b0; cen = 1'b0; cendec = 1'b0; start = 1'b0;
    start_addr = 17'd0; len = 16'd0; rom_ok = 1'b0; rom_data = 8'h00;
    rom_mode = 0; rom_lat = 2; age = 0; cs_prev = 1'b0; prev_addr = 17'd0;
    m_cs = 1'b0; m_urun = 0; cyc = 0; last_nv_cyc = 0; done_cyc = 0; busy_at_done = 1'b0;
    clear_obs();
    @(negedge clk);

    // Reset state
    step(1'b0, 1'b0, 17'd0, 16'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 17'd0, 16'd0, 1'b0, 1'b0);
    check("reset_rom_addr", {15'd0, rom_addr}, 32'd0);

    // Vector table: phrases with slow requests, compare addresses and nibbles
    for (int i = 0; i < 3; i++) begin
      v = vecs[i];
      rom_mode = 0; rom_lat = int'(v.lat);
      clear_obs();
      step(1'b1, 1'b1, v.sa, v.ln, 1'b0, 1'b0);
      for (int k = 1; k < 400 && n_done == 0; k++) step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, (k % 8) == 0);
      check("vec_done", n_done, 1);
      check("vec_done_gap", done_cyc - last_nv_cyc, 1);
      check("vec_busy_at_done", {31'd0, busy_at_done}, 32'd0);
      for (int a = 0; a < int'(v.n_addr); a++) begin
        ea  = v.addrs[67 - 17 * a -: 17];
        got = (a < obs_addrs.size()) ? {15'd0, obs_addrs[a]} : 32'hFFFFFFFF;
        check("vec_addr", got, {15'd0, ea});
      end
      for (int a = 0; a < int'(v.n_nib); a++) begin
        got = (a < obs_nibs.size()) ? {28'd0, obs_nibs[a]} : 32'hFFFFFFFF;
        check("vec_nib", got, {28'd0, v.nibs[31 - 4 * a -: 4]});
      end
    end

    // Empty phrase: done on the next clk, never busy
    clear_obs();
    step(1'b1, 1'b1, 17'h00123, 16'd0, 1'b0, 1'b0);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_busy", {31'd0, busy}, 32'd0);

    // FIFO fills to four bytes, then one consumed byte allows one more fetch
    clear_obs(); rom_lat = 1;
    step(1'b1, 1'b1, 17'h00400, 16'd8, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, 1'b0);
    check("full_fetches", obs_addrs.size(), 4);
    check("full_cs_low", {31'd0, rom_cs}, 32'd0);
    step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, 1'b0);
    check("refill_fetches", obs_addrs.size(), 5);
    for (int k = 0; k < 300 && n_done == 0; k++) step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, (k % 2) == 0);
    check("full_done", n_done, 1);
    check("full_nibs", obs_nibs.size(), 16);

    // Underrun: rom_ok held low, three requests
    clear_obs(); rom_mode = 1;
    step(1'b1, 1'b1, 17'h00500, 16'd4, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, 1'b0);
    end
    check("urun_pulses", n_ur, 3);
    check("urun_no_nib", n_nv, 0);
`ifdef JT7759_UNDERRUN_CNT_EN
    check("urun_cnt_3", {24'd0, urun_cnt}, 32'd3);
`endif
    step(1'b0, 1'b0, 17'd0, 16'd0, 1'b0, 1'b0);
    rom_mode = 0;

    // Restart while the second byte is being fetched
    clear_obs(); rom_lat = 2;
    step(1'b1, 1'b1, 17'h00300, 16'd5, 1'b0, 1'b0);
    for (int k = 0; k < 50 && !(rom_cs === 1'b1 && rom_addr == 17'h00301); k++)
      step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, 1'b0);
    check("abort_at_byte2", {15'd0, rom_addr}, 32'h00301);
    step(1'b1, 1'b1, 17'h00200, 16'd2, 1'b0, 1'b0);
    check("abort_cs", {31'd0, rom_cs}, 32'd1);
    check("abort_addr", {15'd0, rom_addr}, 32'h00200);
    clear_obs();
    for (int k = 0; k < 200 && n_done == 0; k++) step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, (k % 3) == 0);
    check("abort_first_nib", obs_nibs.size() > 0 ? {28'd0, obs_nibs[0]} : 32'hFFFFFFFF, 32'hC);
    check("abort_nib_count", obs_nibs.size(), 4);

    // Reset mid-FETCH, then a stray rom_ok and idle requests
    rom_lat = 3;
    step(1'b1, 1'b1, 17'h00600, 16'd4, 1'b0, 1'b0);
    step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 17'd0, 16'd0, 1'b0, 1'b0);
    check("rst_rom_cs",   {31'd0, rom_cs},    32'd0);
    check("rst_rom_addr", {15'd0, rom_addr},  32'd0);
    check("rst_nib",      {28'd0, nib},       32'd0);
    check("rst_nib_valid",{31'd0, nib_valid}, 32'd0);
    check("rst_busy",     {31'd0, busy},      32'd0);
    check("rst_done",     {31'd0, done},      32'd0);
    check("rst_underrun", {31'd0, underrun},  32'd0);
    clear_obs(); rom_mode = 2;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, 1'b1);
    check("idle_no_fetch", obs_addrs.size(), 0);
    check("idle_no_nib", n_nv, 0);
    check("idle_no_urun", n_ur, 0);
    rom_mode = 0; rom_lat = 1;
    step(1'b1, 1'b1, 17'h00700, 16'd1, 1'b0, 1'b0);
    clear_obs();
    for (int k = 0; k < 50 && n_done == 0; k++) step(1'b1, 1'b0, 17'd0, 16'd0, 1'b1, (k % 4) == 3);
    check("post_rst_nib", obs_nibs.size() > 0 ? {28'd0, obs_nibs[0]} : 32'hFFFFFFFF,
          {28'd0, rom_mem[17'h00700][7:4]});

    // Randomized traffic against the model
    for (int k = 0; k < 2500; k++) begin
      logic        r, s;
      logic [16:0] sa;
      logic [15:0] ln;
      r = ($urandom_range(0, 499) != 0);
      sa = 17'd0; ln = 16'd0;
      if (busy !== 1'b1) s = ($urandom_range(0, 9) == 0);
      else               s = ($urandom_range(0, 199) == 0);
      if (s) begin
        sa = ($urandom_range(0, 3) == 0) ? 17'h1FFF8 + 17'($urandom_range(0, 7)) : 17'($urandom);
        ln = 16'($urandom_range(0, 12));
        rom_lat = $urandom_range(1, 3);
      end
      rom_mode = ($urandom_range(0, 15) == 0) ? 1 : 0;
      step(r, s, sa, ln, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jt7759_romfeed.md
JT7759_ROMFEED -- requirements
Module: jt7759_romfeed

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port cen, input, 1 bit: clock enable for the decoder-side nibble logic.
REQ-004 The block SHALL have the port cendec, input, 1 bit: nibble request strobe, qualified by cen.
REQ-005 The block SHALL have the port start, input, 1 bit: single-clk pulse that begins a phrase.
REQ-006 The block SHALL have the port start_addr, input, 17 bits: first ROM byte address, sampled on start.
REQ-007 The block SHALL have the port len, input, 16 bits: phrase length in bytes, sampled on start.
REQ-008 The block SHALL have the port rom_cs, output, 1 bit: ROM read request.
REQ-009 The block SHALL have the port rom_addr, output, 17 bits: ROM byte address.
REQ-010 The block SHALL have the port rom_data, input, 8 bits: ROM read data.
REQ-011 The block SHALL have the port rom_ok, input, 1 bit: rom_data valid for the current rom_addr.
REQ-012 The block SHALL have the port nib, output, 4 bits: ADPCM nibble sent to the decoder.
REQ-013 The block SHALL have the port nib_valid, output, 1 bit: one-clk pulse meaning nib was updated.
REQ-014 The block SHALL have the port busy, output, 1 bit: high while a phrase is being fed.
REQ-015 The block SHALL have the port done, output, 1 bit: one-clk pulse when the last nibble has been delivered.
REQ-016 The block SHALL have the port underrun, output, 1 bit: one-clk pulse when a request finds the FIFO empty.

Function
REQ-017 The block SHALL implement a state machine with states IDLE, FETCH, WAIT and DRAIN.
REQ-018 In IDLE, start with len!=0 SHALL load addr=start_addr and remaining=len, flush the FIFO, and go to FETCH on the next clk.
REQ-019 In IDLE, start with len==0 SHALL leave the state at IDLE and pulse done on the next clk.
REQ-020 In FETCH the block SHALL drive rom_cs=1 with rom_addr=addr while FIFO count<4 and remaining!=0.
REQ-021 Every clk is FETCH-side; ROM handshake logic SHALL NOT be gated by cen.
REQ-022 A byte SHALL be accepted when rom_cs&&rom_ok are high on a clk edge.
REQ-023 On byte acceptance the block SHALL write rom_data into a 4-entry byte FIFO, increment addr, decrement remaining, and go to WAIT.
REQ-024 WAIT SHALL hold rom_cs=0 for exactly one clk.
REQ-025 WAIT SHALL return to FETCH if remaining!=0, otherwise go to DRAIN.
REQ-026 In FETCH with FIFO count==4, rom_cs SHALL be 0 and the state SHALL stay FETCH until a slot frees.
REQ-027 addr SHALL wrap modulo 2^17 (0x1FFFF+1=0x00000).
REQ-028 Each byte SHALL be consumed as two nibbles, high nibble [7:4] first, then low nibble [3:0]; the byte is popped after its low nibble.
REQ-029 On cen&&cendec with data available, nib SHALL update on that clk edge and nib_valid SHALL be 1 for that clk only; latency from request to nib_valid is 1 clk.
REQ-030 On cen&&cendec with the FIFO empty while busy, nib SHALL hold its value, nib_valid SHALL stay 0 and underrun SHALL pulse.
REQ-031 A FIFO pop and push in the same clk SHALL both occur, with count unchanged.
REQ-032 In DRAIN, after the low nibble of the last byte is delivered, the block SHALL pulse done on the following clk and go to IDLE.
REQ-033 busy SHALL be 1 in FETCH, WAIT and DRAIN, and 0 in IDLE.
REQ-034 start while busy SHALL abort the current phrase, flush the FIFO, reload addr and remaining, and go to FETCH.
REQ-035 On start while busy, a pending rom_ok in the same clk SHALL be ignored.
REQ-036 cendec requests in IDLE SHALL be ignored: no nib_valid and no underrun.

Reset
REQ-037 While rst_n==0 at a clk edge, the block SHALL set state=IDLE, FIFO count=0, addr=0 and remaining=0.
REQ-038 While rst_n==0 at a clk edge, the block SHALL set rom_cs=0, rom_addr=0, nib=0, nib_valid=0, busy=0, done=0 and underrun=0.
REQ-039 Reset asserted mid-phrase SHALL discard all buffered data, and the block SHALL ignore rom_ok until the next start.

Configuration
REQ-040 With macro JT7759_UNDERRUN_CNT_EN defined, the block SHALL add an output port urun_cnt, 8 bits.
REQ-041 urun_cnt SHALL increment on each underrun pulse, saturate at 255, clear on start, and reset to 0.
REQ-042 Without JT7759_UNDERRUN_CNT_EN, the port and counter SHALL be absent, and the underrun pulse SHALL be unchanged.

Verification
REQ-043 Bench: start_addr=0x00100, len=3, ROM bytes 0xA5,0x3C,0x7E, rom_ok 2 clk after rom_cs -> nibbles A,5,3,C,7,E on 6 requests; done 1 clk after the 6th nib_valid; busy falls with done.
REQ-044 Bench: start_addr=0x1FFFE, len=4 -> rom_addr sequence 0x1FFFE,0x1FFFF,0x00000,0x00001.
REQ-045 Bench: len=8 and no cendec -> exactly 4 accepted bytes, then rom_cs stays 0; one byte consumed (2 requests) -> exactly one more fetch.
REQ-046 Bench: rom_ok held low, cendec requests ×3 -> 3 underrun pulses, no nib_valid, urun_cnt=3 when the macro is defined.
REQ-047 Bench: start during byte 2 of len=5, new start_addr=0x00200 -> next rom_addr=0x00200; first nib is the high nibble of ROM[0x00200].
REQ-048 Bench: rst_n=0 for 1 clk mid-FETCH -> all outputs 0 on the next clk; a later rom_ok causes no FIFO write.
